decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue_if.sv | 43 ++++
 rtl/decode_queue.sv | 175 +++++++++++++++++
 tb/tb_decode_queue.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// Fetch-to-issue bundle for the decode queue: fetch handshake, flush, issue
// handshake and the registered decoded fields presented to EX.
interface decode_queue_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [11:0] csr_addr;
  logic        Branch;
  logic        MemREAD;
  logic        MemtoReg;
  logic [1:0]  MemWrite;
  logic        ALUSrc;
  logic        RegWrite;
  logic        csr_we;
  logic        illegal;

  // The queue itself.
  modport slave (
    input  if_valid, if_instr, if_pc, flush, id_ready,
    output if_ready, id_valid, id_pc, opcode, rd, funct3, rs1, rs2, funct7,
           csr_addr, Branch, MemREAD, MemtoReg, MemWrite, ALUSrc, RegWrite,
           csr_we, illegal
  );

  // Fetch stage plus EX stage (or a testbench standing in for both).
  modport master (
    output if_valid, if_instr, if_pc, flush, id_ready,
    input  if_ready, id_valid, id_pc, opcode, rd, funct3, rs1, rs2, funct7,
           csr_addr, Branch, MemREAD, MemtoReg, MemWrite, ALUSrc, RegWrite,
           csr_we, illegal
  );
endinterface

// File: rtl/decode_queue.sv
// Instruction buffer (circular FIFO of {pc, instr}) feeding a registered RV32
// decode stage with valid/ready handshake, same-cycle bypass and flush.
module decode_queue #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  decode_queue_if.slave  bus
);

  localparam int             AW        = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_CNT = (AW + 1)'(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [11:0] csr_addr;
    logic        branch;
    logic        mem_read;
    logic        mem_to_reg;
    logic [1:0]  mem_write;
    logic        alu_src;
    logic        reg_write;
    logic        csr_we;
    logic        illegal;
  } bundle_t;

  function automatic bundle_t decode(input logic [31:0] instr, input logic [31:0] pc);
    bundle_t    b;
    logic [4:0] ctrl;
    b          = '0;
    ctrl       = 5'b00000;
    b.pc       = pc;
    b.opcode   = instr[6:0];
    b.rd       = instr[11:7];
    b.funct3   = instr[14:12];
    b.rs1      = instr[19:15];
    b.rs2      = instr[24:20];
    b.funct7   = instr[31:25];
    b.csr_addr = instr[31:20];
    b.csr_we   = (b.opcode == OPC_SYSTEM) && (b.funct3 != 3'b000) && (b.funct3 != 3'b100);
    case (b.opcode)
      OPC_LUI, OPC_AUIPC, OPC_OP_IMM: ctrl = 5'b00011;
      OPC_JAL, OPC_JALR:              ctrl = 5'b10011;
      OPC_BRANCH:                     ctrl = 5'b10000;
      OPC_LOAD:                       ctrl = 5'b01111;
      OPC_OP:                         ctrl = 5'b00001;
      OPC_STORE: begin
        ctrl = 5'b00010;
        case (b.funct3)
          3'b000:  b.mem_write = 2'b01;
          3'b001:  b.mem_write = 2'b10;
          3'b010:  b.mem_write = 2'b11;
          default: b.illegal   = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        ctrl = b.csr_we ? 5'b00001 : 5'b00000;
        if (b.funct3 == 3'b100) b.illegal = 1'b1;
      end
      default: b.illegal = 1'b1;
    endcase
    {b.branch, b.mem_read, b.mem_to_reg, b.alu_src, b.reg_write} = ctrl;
    // An illegal bundle must not have any architectural side effect downstream.
    if (b.illegal) begin
      b.reg_write = 1'b0;
      b.mem_write = 2'b00;
      b.mem_read  = 1'b0;
      b.branch    = 1'b0;
      b.csr_we    = 1'b0;
    end
    return b;
  endfunction

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          valid_q, valid_d;
  bundle_t       bundle_q, bundle_d;

  logic        full, empty, push, load, pop, bypass, fifo_wr;
  logic [31:0] src_instr, src_pc;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // Ready looks only at the registered count, so a pop cannot free a slot the same cycle.
  assign bus.if_ready = rst_n && !full && !bus.flush;

  assign push    = bus.if_valid && bus.if_ready;
  assign load    = !valid_q || bus.id_ready;
  assign pop     = load && !empty;
  assign bypass  = load && empty && push;
  assign fifo_wr = push && !bypass;

  always_comb begin
    src_instr = bus.if_instr;
    src_pc    = bus.if_pc;
    if (pop) begin
      src_instr = instr_mem_q[rd_ptr_q];
      src_pc    = pc_mem_q[rd_ptr_q];
    end
    bundle_d = decode(src_instr, src_pc);
    valid_d  = valid_q;
    if (load) valid_d = pop || bypass;
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      pc_mem_q[wr_ptr_q]    <= bus.if_pc;
      instr_mem_q[wr_ptr_q] <= bus.if_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else if (bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_wr, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      valid_q <= valid_d;
      if (pop || bypass) bundle_q <= bundle_d;
    end
  end

  assign bus.id_valid = valid_q;
  assign bus.id_pc    = bundle_q.pc;
  assign bus.opcode   = bundle_q.opcode;
  assign bus.rd       = bundle_q.rd;
  assign bus.funct3   = bundle_q.funct3;
  assign bus.rs1      = bundle_q.rs1;
  assign bus.rs2      = bundle_q.rs2;
  assign bus.funct7   = bundle_q.funct7;
  assign bus.csr_addr = bundle_q.csr_addr;
  assign bus.Branch   = bundle_q.branch;
  assign bus.MemREAD  = bundle_q.mem_read;
  assign bus.MemtoReg = bundle_q.mem_to_reg;
  assign bus.MemWrite = bundle_q.mem_write;
  assign bus.ALUSrc   = bundle_q.alu_src;
  assign bus.RegWrite = bundle_q.reg_write;
  assign bus.csr_we   = bundle_q.csr_we;
  assign bus.illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: reset, bypass, backpressure/full, decode
// table, flush and mid-stream reset, with hand-computed expectations.
module tb_decode_queue;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  decode_queue_if bus ();

  decode_queue #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [4:0] ctrl;
  assign ctrl = {bus.Branch, bus.MemREAD, bus.MemtoReg, bus.ALUSrc, bus.RegWrite};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_instr = instr;
    bus.if_pc    = pc;
  endtask

  // Decode table: instr, {Branch,MemREAD,MemtoReg,ALUSrc,RegWrite}, MemWrite, csr_we, illegal
  localparam int NV = 17;
  logic [31:0] v_instr [NV] = '{32'h00A00093, 32'h00000537, 32'h00000517, 32'h0000006F,
                                32'h00008067, 32'h00000063, 32'h0000A103, 32'h00208023,
                                32'h00209023, 32'h0020A023, 32'h0020B023, 32'h002081B3,
                                32'h30529073, 32'h00000073, 32'h00004073, 32'hFFFFFFFF,
                                32'h0000F073};
  logic [4:0]  v_ctrl  [NV] = '{5'b00011, 5'b00011, 5'b00011, 5'b10011, 5'b10011, 5'b10000,
                                5'b01111, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00001,
                                5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
  logic [1:0]  v_mw    [NV] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01,
                                2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic        v_csr   [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
  logic        v_ill   [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0};

  initial begin
    rst_n        = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_instr = '0;
    bus.if_pc    = '0;
    bus.flush    = 1'b0;
    bus.id_ready = 1'b0;

    // Reset
    @(negedge clk);
    check_eq("rst_if_ready_low", 32'(bus.if_ready), 32'd0);
    tick();
    check_eq("rst_id_valid", 32'(bus.id_valid), 32'd0);
    check_eq("rst_id_pc", bus.id_pc, 32'd0);
    check_eq("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_release_if_ready", 32'(bus.if_ready), 32'd1);

    // Bypass: addi x1,x0,10
    bus.id_ready = 1'b1;
    offer(32'h00A00093, 32'h100);
    tick();
    bus.if_valid = 1'b0;
    check_eq("byp_id_valid", 32'(bus.id_valid), 32'd1);
    check_eq("byp_opcode", 32'(bus.opcode), 32'h13);
    check_eq("byp_rd", 32'(bus.rd), 32'd1);
    check_eq("byp_ctrl", 32'(ctrl), 32'b00011);
    check_eq("byp_id_pc", bus.id_pc, 32'h100);
    check_eq("byp_csr_addr", 32'(bus.csr_addr), 32'h00A);
    tick();
    check_eq("byp_retired", 32'(bus.id_valid), 32'd0);

    // Backpressure: DEPTH+1 pushes with id_ready low
    bus.id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer({12'(i), 5'd0, 3'd0, 5'(i + 1), 7'h13}, 32'h200 + 32'(4 * i));
      #1;
      check_eq($sformatf("bp_ready_%0d", i), 32'(bus.if_ready), 32'd1);
      tick();
    end
    bus.if_valid = 1'b0;
    #1;
    check_eq("bp_full_ready", 32'(bus.if_ready), 32'd0);
    tick();
    check_eq("bp_hold_valid", 32'(bus.id_valid), 32'd1);
    check_eq("bp_hold_pc", bus.id_pc, 32'h200);
    check_eq("bp_hold_rd", 32'(bus.rd), 32'd1);
    // Full with a pop this cycle: ready must still be low, offered instr dropped
    bus.id_ready = 1'b1;
    offer(32'h00000013, 32'hDEAD);
    #1;
    check_eq("bp_full_pop_ready", 32'(bus.if_ready), 32'd0);
    tick();
    bus.if_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      check_eq($sformatf("bp_out_valid_%0d", i), 32'(bus.id_valid), 32'd1);
      check_eq($sformatf("bp_out_pc_%0d", i), bus.id_pc, 32'h200 + 32'(4 * i));
      check_eq($sformatf("bp_out_rd_%0d", i), 32'(bus.rd), 32'(i + 1));
      tick();
    end
    check_eq("bp_drained", 32'(bus.id_valid), 32'd0);

    // Decode table streamed back-to-back through bypass
    for (int k = 0; k < NV; k++) begin
      offer(v_instr[k], 32'h400 + 32'(4 * k));
      tick();
      check_eq($sformatf("dec%0d_ctrl", k), 32'(ctrl), 32'(v_ctrl[k]));
      check_eq($sformatf("dec%0d_memwrite", k), 32'(bus.MemWrite), 32'(v_mw[k]));
      check_eq($sformatf("dec%0d_csr_we", k), 32'(bus.csr_we), 32'(v_csr[k]));
      check_eq($sformatf("dec%0d_illegal", k), 32'(bus.illegal), 32'(v_ill[k]));
      check_eq($sformatf("dec%0d_opcode", k), 32'(bus.opcode), 32'(v_instr[k][6:0]));
      if (k == 12) check_eq("dec_csrrw_addr", 32'(bus.csr_addr), 32'h305);
    end
    bus.if_valid = 1'b0;
    tick();

    // Flush with 1 in output + 3 in FIFO and a simultaneous push
    bus.id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(32'h00000013, 32'h600 + 32'(4 * i));
      tick();
    end
    offer(32'h00000013, 32'hBAD0);
    bus.flush = 1'b1;
    #1;
    check_eq("fl_if_ready_low", 32'(bus.if_ready), 32'd0);
    tick();
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    check_eq("fl_id_valid", 32'(bus.id_valid), 32'd0);
    bus.id_ready = 1'b1;
    tick();
    check_eq("fl_still_empty", 32'(bus.id_valid), 32'd0);
    offer(32'h00500113, 32'h700);
    tick();
    bus.if_valid = 1'b0;
    check_eq("fl_next_valid", 32'(bus.id_valid), 32'd1);
    check_eq("fl_next_pc", bus.id_pc, 32'h700);
    tick();
    check_eq("fl_next_drained", 32'(bus.id_valid), 32'd0);

    // Reset mid-stream
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h0000A103, 32'h800 + 32'(4 * i));
      tick();
    end
    bus.if_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mr_if_ready_low", 32'(bus.if_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("mr_id_valid", 32'(bus.id_valid), 32'd0);
    check_eq("mr_id_pc", bus.id_pc, 32'd0);
    check_eq("mr_opcode", 32'(bus.opcode), 32'd0);
    check_eq("mr_ctrl", 32'(ctrl), 32'd0);
    check_eq("mr_memwrite", 32'(bus.MemWrite), 32'd0);
    check_eq("mr_csr_addr", 32'(bus.csr_addr), 32'd0);
    check_eq("mr_if_ready_high", 32'(bus.if_ready), 32'd1);
    bus.id_ready = 1'b1;
    tick();
    check_eq("mr_no_stale_1", 32'(bus.id_valid), 32'd0);
    tick();
    check_eq("mr_no_stale_2", 32'(bus.id_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
